// File: rtl/tiles_pkg.sv
// Shared definitions for the tile sequencer: FSM encoding, scoring table and load timing.
package tiles_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  localparam int unsigned PTS_LOW     = 10;
  localparam int unsigned PTS_MID     = 20;
  localparam int unsigned PTS_HIGH    = 30;
  localparam int unsigned COMBO_MID   = 4;
  localparam int unsigned COMBO_HIGH  = 8;
  localparam int unsigned LOAD_CYCLES = 4;

  // Points for a hit, chosen from the combo value before it increments.
  function automatic logic [4:0] beat_points(input logic [7:0] combo);
    if (combo >= 8'(COMBO_HIGH)) return 5'(PTS_HIGH);
    else if (combo >= 8'(COMBO_MID)) return 5'(PTS_MID);
    else return 5'(PTS_LOW);
  endfunction

endpackage

// File: rtl/tile_sequencer_if.sv
// Song ROM port bundle between the sequencer (master) and the song memory (slave).
interface tile_sequencer_if #(
  parameter int unsigned N_KEYS  = 12,
  parameter int unsigned FRAME_W = 8,
  parameter int unsigned HOLD_W  = 4
);
  // Handshake: no valid/ready; master drives rom_addr, slave returns note/hold exactly one cycle later, never stalls.
  logic [FRAME_W-1:0] rom_addr;
  logic [N_KEYS-1:0]  rom_note;
  logic [HOLD_W-1:0]  rom_hold;

  modport master (output rom_addr, input rom_note, input rom_hold);
  modport slave  (input rom_addr, output rom_note, output rom_hold);
endinterface

// File: rtl/beat_timer.sv
// Pausable beat counter: counts 0..BEAT_CYCLES-1 while run is high, holds while low.
module beat_timer #(
  parameter int unsigned BEAT_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic beat,
  output logic beat_end
);
  localparam int unsigned CNT_W = (BEAT_CYCLES > 2) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(BEAT_CYCLES / 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             beat_q, beat_d;

  assign beat_end = run && (cnt_q == LAST);
  assign beat     = beat_q;

  // beat is a registered view of the running counter, so it drops as soon as counting stops.
  always_comb begin
    cnt_d  = cnt_q;
    beat_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      beat_d = (cnt_q < HALF);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      beat_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      beat_q <= beat_d;
    end
  end
endmodule

// File: rtl/tile_sequencer.sv
// Rhythm-game sequencer: walks a song ROM frame by frame, judges keys per beat, keeps score and combo.
module tile_sequencer
  import tiles_pkg::*;
#(
  parameter int unsigned N_KEYS      = 12,
  parameter int unsigned FRAME_W     = 8,
  parameter int unsigned HOLD_W      = 4,
  parameter int unsigned BEAT_CYCLES = 50000000,
  parameter int unsigned SCORE_W     = 17,
  parameter int unsigned MAX_SCORE   = 9990
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic [FRAME_W-1:0] song_len,
  input  logic [N_KEYS-1:0]  keys,
  output logic [FRAME_W-1:0] rom_addr,
  input  logic [N_KEYS-1:0]  rom_note,
  input  logic [HOLD_W-1:0]  rom_hold,
  output logic [N_KEYS-1:0]  curr_note,
  output logic [N_KEYS-1:0]  next_note,
  output logic [HOLD_W-1:0]  hold_left,
  output logic               beat,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         combo,
  output logic [2:0]         state,
  output logic               done
);
  localparam logic [SCORE_W:0] SCORE_CEIL = (SCORE_W + 1)'(MAX_SCORE);

  seq_state_e         state_q, state_d;
  logic [1:0]         load_cnt_q, load_cnt_d;
  logic [1:0]         fetch_q, fetch_d;
  logic [FRAME_W-1:0] song_len_q, song_len_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:0] rom_addr_q, rom_addr_d;
  logic [N_KEYS-1:0]  curr_q, curr_d, next_q, next_d;
  logic [HOLD_W-1:0]  hold_q, hold_d, next_hold_q, next_hold_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [7:0]         combo_q, combo_d;
  logic               note_hit_q, note_hit_d, rest_bad_q, rest_bad_d;
  logic               done_q, done_d;

  logic               run, clear, beat_end, beat_hit, last_frame;
  logic [SCORE_W:0]   score_sum;

  function automatic logic [HOLD_W-1:0] eff_hold(input logic [HOLD_W-1:0] h);
    return (h == '0) ? HOLD_W'(1) : h;
  endfunction

  // A cycle carrying a pause request is neither counted nor judged.
  assign run   = (state_q == ST_PLAY) && !pause;
  assign clear = (state_q != ST_PLAY) && (state_q != ST_PAUSE);

  beat_timer #(.BEAT_CYCLES(BEAT_CYCLES)) u_beat_timer (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .clear    (clear),
    .beat     (beat),
    .beat_end (beat_end)
  );

  assign beat_hit   = (curr_q != '0) ? (note_hit_q || (keys == curr_q))
                                     : (!rest_bad_q && (keys == '0));
  assign last_frame = ({1'b0, frame_q} + (FRAME_W + 1)'(1)) == {1'b0, song_len_q};
  assign score_sum  = {1'b0, score_q} + {{(SCORE_W - 4){1'b0}}, beat_points(combo_q)};

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    fetch_d     = fetch_q;
    song_len_d  = song_len_q;
    frame_d     = frame_q;
    rom_addr_d  = rom_addr_q;
    curr_d      = curr_q;
    next_d      = next_q;
    hold_d      = hold_q;
    next_hold_d = next_hold_q;
    score_d     = score_q;
    combo_d     = combo_q;
    note_hit_d  = note_hit_q;
    rest_bad_d  = rest_bad_q;

    // Look-ahead fetch after an advance; rom_note is valid on the second cycle.
    if (fetch_q == 2'd2) begin
      fetch_d = 2'd1;
    end else if (fetch_q == 2'd1) begin
      fetch_d     = 2'd0;
      next_d      = last_frame ? '0 : rom_note;
      next_hold_d = last_frame ? '0 : eff_hold(rom_hold);
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          song_len_d = song_len;
          score_d    = '0;
          combo_d    = '0;
          frame_d    = '0;
          rom_addr_d = '0;
          note_hit_d = 1'b0;
          rest_bad_d = 1'b0;
          fetch_d    = 2'd0;
          load_cnt_d = 2'd0;
          state_d    = (song_len == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_cnt_d = load_cnt_q + 2'd1;
        case (load_cnt_q)
          2'd0: rom_addr_d = FRAME_W'(1);
          2'd1: begin
            curr_d = rom_note;
            hold_d = eff_hold(rom_hold);
          end
          2'd2: begin
            next_d      = (song_len_q > FRAME_W'(1)) ? rom_note : '0;
            next_hold_d = (song_len_q > FRAME_W'(1)) ? eff_hold(rom_hold) : '0;
          end
          default: state_d = ST_PLAY;
        endcase
      end
      ST_PLAY: begin
        if (pause) begin
          state_d = ST_PAUSE;
        end else if (beat_end) begin
          if (beat_hit) begin
            score_d = (score_sum > SCORE_CEIL) ? SCORE_CEIL[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
            combo_d = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
          end else begin
            combo_d = '0;
          end
          note_hit_d = 1'b0;
          rest_bad_d = 1'b0;
          if (hold_q > HOLD_W'(1)) begin
            hold_d = hold_q - HOLD_W'(1);
          end else if (last_frame) begin
            state_d     = ST_DONE;
            curr_d      = '0;
            next_d      = '0;
            hold_d      = '0;
            next_hold_d = '0;
            fetch_d     = 2'd0;
          end else begin
            curr_d     = next_q;
            hold_d     = next_hold_q;
            frame_d    = frame_q + FRAME_W'(1);
            rom_addr_d = frame_q + FRAME_W'(2);
            fetch_d    = 2'd2;
          end
        end else begin
          if ((curr_q != '0) && (keys == curr_q)) note_hit_d = 1'b1;
          if (keys != '0) rest_bad_d = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (pause) state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      load_cnt_q  <= '0;
      fetch_q     <= '0;
      song_len_q  <= '0;
      frame_q     <= '0;
      rom_addr_q  <= '0;
      curr_q      <= '0;
      next_q      <= '0;
      hold_q      <= '0;
      next_hold_q <= '0;
      score_q     <= '0;
      combo_q     <= '0;
      note_hit_q  <= 1'b0;
      rest_bad_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      fetch_q     <= fetch_d;
      song_len_q  <= song_len_d;
      frame_q     <= frame_d;
      rom_addr_q  <= rom_addr_d;
      curr_q      <= curr_d;
      next_q      <= next_d;
      hold_q      <= hold_d;
      next_hold_q <= next_hold_d;
      score_q     <= score_d;
      combo_q     <= combo_d;
      note_hit_q  <= note_hit_d;
      rest_bad_q  <= rest_bad_d;
      done_q      <= done_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign curr_note = curr_q;
  assign next_note = next_q;
  assign hold_left = hold_q;
  assign score     = score_q;
  assign combo     = combo_q;
  assign state     = state_q;
  assign done      = done_q;
endmodule

// File: tb/tb_tile_sequencer.sv
// Bench for tile_sequencer: song-level reference model compared every cycle, plus directed scenarios.
module tb_tile_sequencer;
  import tiles_pkg::*;

  localparam int N_KEYS = 12, FRAME_W = 8, HOLD_W = 4, BC = 8, SCORE_W = 17, MAX_SC = 9990;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, pause = 1'b0;
  logic [FRAME_W-1:0] song_len = '0;
  logic [N_KEYS-1:0]  keys = '0;
  logic [N_KEYS-1:0]  curr_note, next_note;
  logic [HOLD_W-1:0]  hold_left;
  logic               beat, done;
  logic [SCORE_W-1:0] score;
  logic [7:0]         combo;
  logic [2:0]         state;

  int n_checks = 0, n_fail = 0;
  bit chk_en = 0;

  tile_sequencer_if #(.N_KEYS(N_KEYS), .FRAME_W(FRAME_W), .HOLD_W(HOLD_W)) rif ();

  tile_sequencer #(.N_KEYS(N_KEYS), .FRAME_W(FRAME_W), .HOLD_W(HOLD_W), .BEAT_CYCLES(BC),
                   .SCORE_W(SCORE_W), .MAX_SCORE(MAX_SC)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .song_len(song_len), .keys(keys),
    .rom_addr(rif.rom_addr), .rom_note(rif.rom_note), .rom_hold(rif.rom_hold),
    .curr_note(curr_note), .next_note(next_note), .hold_left(hold_left), .beat(beat),
    .score(score), .combo(combo), .state(state), .done(done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- song ROM, 1-cycle latency ----------------
  logic [N_KEYS-1:0] song_note [256];
  logic [HOLD_W-1:0] song_hold [256];
  always @(posedge clk) begin
    rif.rom_note <= song_note[rif.rom_addr];
    rif.rom_hold <= song_hold[rif.rom_addr];
  end

  // ---------------- reference model (song position, beat position, score rules) ----------------
  seq_state_e m_st;
  int m_lc, m_len, m_frame, m_hold, m_pos, m_score, m_combo, m_pts;
  bit m_hit, m_bad, m_beat, m_judge;
  logic [N_KEYS-1:0] m_cn;

  function automatic int eff(input int h);
    return (h == 0) ? 1 : h;
  endfunction

  function automatic logic [N_KEYS-1:0] model_curr();
    return (m_st == ST_PLAY || m_st == ST_PAUSE) ? song_note[m_frame] : '0;
  endfunction

  function automatic logic [N_KEYS-1:0] model_next();
    if (m_st != ST_PLAY && m_st != ST_PAUSE) return '0;
    return (m_frame + 1 < m_len) ? song_note[m_frame + 1] : '0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_st = ST_IDLE; m_lc = 0; m_len = 0; m_frame = 0; m_hold = 0; m_pos = 0;
      m_score = 0; m_combo = 0; m_hit = 0; m_bad = 0; m_beat = 0;
    end else begin
      m_cn   = model_curr();
      m_beat = (m_st == ST_PLAY) && !pause && (m_pos < BC / 2);
      case (m_st)
        ST_IDLE, ST_DONE: if (start) begin
          m_score = 0; m_combo = 0;
          if (song_len == 0) m_st = ST_DONE;
          else begin
            m_st = ST_LOAD; m_lc = 0; m_len = int'(song_len); m_frame = 0; m_hit = 0; m_bad = 0; m_pos = 0;
          end
        end
        ST_LOAD: if (m_lc == 3) begin
          m_st = ST_PLAY; m_pos = 0; m_hold = eff(int'(song_hold[0]));
        end else m_lc++;
        ST_PLAY: if (pause) m_st = ST_PAUSE;
        else if (m_pos == BC - 1) begin
          m_judge = (m_cn != 0) ? (m_hit || keys == m_cn) : (!m_bad && keys == 0);
          if (m_judge) begin
            m_pts   = (m_combo < 4) ? 10 : ((m_combo < 8) ? 20 : 30);
            m_score = (m_score + m_pts > MAX_SC) ? MAX_SC : m_score + m_pts;
            m_combo = (m_combo == 255) ? 255 : m_combo + 1;
          end else m_combo = 0;
          m_hit = 0; m_bad = 0; m_pos = 0;
          if (m_hold > 1) m_hold--;
          else if (m_frame == m_len - 1) begin m_st = ST_DONE; m_hold = 0; end
          else begin m_frame++; m_hold = eff(int'(song_hold[m_frame])); end
        end else begin
          if (m_cn != 0 && keys == m_cn) m_hit = 1;
          if (keys != 0) m_bad = 1;
          m_pos++;
        end
        ST_PAUSE: if (pause) m_st = ST_PLAY;
        default: m_st = ST_IDLE;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && chk_en) begin
      check("state", longint'(state), longint'(m_st));
      check("score", longint'(score), longint'(m_score));
      check("combo", longint'(combo), longint'(m_combo));
      check("done", longint'(done), longint'(m_st == ST_DONE));
      check("beat", longint'(beat), longint'(m_beat));
      if (m_st != ST_LOAD) begin
        check("curr_note", longint'(curr_note), longint'(model_curr()));
        check("hold_left", longint'(hold_left),
              longint'((m_st == ST_PLAY || m_st == ST_PAUSE) ? m_hold : 0));
        if (m_pos >= 2 || m_frame == 0 || (m_st != ST_PLAY && m_st != ST_PAUSE))
          check("next_note", longint'(next_note), longint'(model_next()));
      end
    end
  end

  // ---------------- key driver ----------------
  int key_mode = 0;
  logic [N_KEYS-1:0] key_force = '0;
  always @(posedge clk) begin
    #1;
    case (key_mode)
      1: keys = model_curr();
      2: if ($urandom_range(0, 99) < 60) keys = model_curr();
         else if ($urandom_range(0, 1) == 0) keys = '0;
         else keys = N_KEYS'(1) << $urandom_range(0, N_KEYS - 1);
      3: keys = key_force;
      default: keys = '0;
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin tick(); n++; end
    check({name, "_reached_done"}, longint'(done === 1'b1), 1);
  endtask

  task automatic clear_song();
    for (int i = 0; i < 256; i++) begin song_note[i] = '0; song_hold[i] = '0; end
  endtask

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: run did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    clear_song();
    #1 reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk_en = 1;
    check("reset_state", longint'(state), longint'(ST_IDLE));
    check("reset_score", longint'(score), 0);

    // three one-beat notes, every beat hit
    song_note[0] = 12'h001; song_note[1] = 12'h002; song_note[2] = 12'h004;
    song_hold[0] = 4'd1; song_hold[1] = 4'd1; song_hold[2] = 4'd1;
    song_len = 8'd3; key_mode = 1;
    pulse_start();
    repeat (27) tick();
    check("t1_not_done_yet", longint'(done), 0);
    tick();
    check("t1_done_edge", longint'(done), 1);
    check("t1_score", longint'(score), 30);
    check("t1_combo", longint'(combo), 3);

    // single long note, combo climbs through all point tiers
    clear_song();
    song_note[0] = 12'h010; song_hold[0] = 4'd12; song_len = 8'd1;
    pulse_start();
    repeat (4) tick();
    check("t2_hold_first", longint'(hold_left), 12);
    repeat (8) tick();
    check("t2_hold_second", longint'(hold_left), 11);
    wait_done(200, "t2");
    check("t2_score", longint'(score), 240);
    check("t2_combo", longint'(combo), 12);

    // rest disturbed by a one-cycle key pulse, then a clean rest, then a note
    clear_song();
    song_hold[0] = 4'd1; song_hold[1] = 4'd1; song_note[2] = 12'h001; song_hold[2] = 4'd0;
    song_len = 8'd3;
    pulse_start();
    repeat (7) tick();
    key_force = 12'h001; key_mode = 3;
    tick();
    key_mode = 1;
    repeat (4) tick();
    check("t3_rest_miss_score", longint'(score), 0);
    wait_done(200, "t3");
    check("t3_score", longint'(score), 20);
    check("t3_combo", longint'(combo), 2);

    // pause three cycles into a beat for twenty cycles
    clear_song();
    song_note[0] = 12'h002; song_hold[0] = 4'd2; song_len = 8'd1;
    pulse_start();
    repeat (7) tick();
    pause = 1'b1; tick(); pause = 1'b0;
    for (int i = 0; i < 19; i++) begin
      check("t4_beat_paused", longint'(beat), 0);
      tick();
    end
    check("t4_state_paused", longint'(state), longint'(ST_PAUSE));
    pause = 1'b1; tick(); pause = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t4_hold_before_end", longint'(hold_left), 2);
      tick();
    end
    check("t4_hold_before_end", longint'(hold_left), 2);
    tick();
    check("t4_hold_after_end", longint'(hold_left), 1);
    wait_done(200, "t4");

    // long all-hit song drives score into the ceiling
    clear_song();
    for (int i = 0; i < 30; i++) begin
      song_note[i] = N_KEYS'(1) << $urandom_range(0, N_KEYS - 1);
      song_hold[i] = 4'd15;
    end
    song_len = 8'd30;
    pulse_start();
    wait_done(5000, "t5");
    check("t5_score_ceiling", longint'(score), 9990);
    check("t5_combo_sat", longint'(combo), 255);

    // asynchronous reset in the middle of play
    pulse_start();
    repeat (30) tick();
    reset = 1'b1;
    #1;
    check("t5_rst_state", longint'(state), longint'(ST_IDLE));
    check("t5_rst_score", longint'(score), 0);
    check("t5_rst_curr", longint'(curr_note), 0);
    check("t5_rst_hold", longint'(hold_left), 0);
    check("t5_rst_combo", longint'(combo), 0);
    tick(); tick();
    reset = 1'b0;

    // empty song, ignored restart, start beating pause
    song_len = 8'd0;
    pulse_start();
    check("t6_empty_done", longint'(done), 1);
    check("t6_empty_score", longint'(score), 0);
    clear_song();
    song_note[0] = 12'h040; song_hold[0] = 4'd2; song_note[1] = 12'h080; song_hold[1] = 4'd1;
    song_len = 8'd2;
    pulse_start();
    repeat (10) tick();
    pulse_start();
    check("t6_start_ignored", longint'(state), longint'(ST_PLAY));
    wait_done(200, "t6");
    start = 1'b1; pause = 1'b1; tick(); start = 1'b0; pause = 1'b0;
    check("t6_start_wins", longint'(state), longint'(ST_LOAD));
    wait_done(200, "t6b");

    // randomized songs with random keys, pauses, ignored starts and song_len churn
    key_mode = 2;
    for (int s = 0; s < 8; s++) begin
      int len, n;
      clear_song();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        song_note[i] = ($urandom_range(0, 3) == 0) ? '0 : N_KEYS'(1) << $urandom_range(0, N_KEYS - 1);
        song_hold[i] = HOLD_W'($urandom_range(0, 3));
      end
      song_len = FRAME_W'(len);
      pulse_start();
      n = 0;
      while (done !== 1'b1 && n < 2000) begin
        if ($urandom_range(0, 99) < 5) pause = 1'b1;
        if ($urandom_range(0, 99) < 3) start = 1'b1;
        if ($urandom_range(0, 99) < 5) song_len = FRAME_W'($urandom_range(0, 255));
        tick();
        pause = 1'b0; start = 1'b0;
        n++;
      end
      check("rnd_reached_done", longint'(done === 1'b1), 1);
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tile_sequencer.md
TILE_SEQUENCER -- requirements
Module: tile_sequencer

Interface
REQ-001 SHALL have parameter N_KEYS, default 12, one-hot note/key width.
REQ-002 SHALL have parameter FRAME_W, default 8, song frame index width.
REQ-003 SHALL have parameter HOLD_W, default 4, hold-length width in beats.
REQ-004 SHALL have parameter BEAT_CYCLES, default 50000000, clk cycles per beat, must be >= 4.
REQ-005 SHALL have parameter SCORE_W, default 17, and MAX_SCORE, default 9990, saturation ceiling.
REQ-006 SHALL have ports:
  clk  in  1  system clock;
  reset  in  1  reset, asynchronous, active-high;
  start  in  1  single-cycle start/restart pulse;
  pause  in  1  single-cycle pause-toggle pulse;
  song_len  in  FRAME_W  number of frames in song;
  keys  in  N_KEYS  synchronised one-hot key state;
  rom_addr  out  FRAME_W  song ROM address;
  rom_note  in  N_KEYS  ROM note data, valid 1 cycle after rom_addr;
  rom_hold  in  HOLD_W  ROM hold length, same timing;
  curr_note  out  N_KEYS  note now being judged;
  next_note  out  N_KEYS  following note, 0 past song end;
  hold_left  out  HOLD_W  beats remaining on curr_note incl. current;
  beat  out  1  metronome, high for first BEAT_CYCLES/2 cycles of each beat;
  score  out  SCORE_W  accumulated score;
  combo  out  8  consecutive hit beats;
  state  out  3  FSM state encoding;
  done  out  1  high while in DONE.

Function
REQ-007 FSM states SHALL be IDLE, LOAD, PLAY, PAUSE, DONE.
REQ-008 IDLE/DONE + start: song_len==0 -> DONE; else -> LOAD, clearing score, combo, frame index, hit flags.
REQ-009 LOAD SHALL fetch frame 0 into curr, frame 1 into next (next=0, hold 0 if song_len==1), then enter PLAY with beat counter at 0; LOAD duration fixed at 4 cycles.
REQ-010 rom_hold==0 SHALL be treated as 1; hold_left loaded with effective hold on each frame entry.
REQ-011 Beat counter SHALL run 0..BEAT_CYCLES-1 only in PLAY; beat-end = counter at BEAT_CYCLES-1.
REQ-012 Judging: non-rest note (curr_note!=0) beat is a hit if keys==curr_note on any cycle of the beat (sticky flag); rest (curr_note==0) is a hit only if keys==0 on every cycle of the beat.
REQ-013 At beat-end on hit: score += points, points=10 if combo<4, 20 if 4<=combo<8, 30 if combo>=8 (pre-increment combo); combo increments, saturating at 255.
REQ-014 At beat-end on miss: combo SHALL clear to 0, score unchanged.
REQ-015 score SHALL saturate at MAX_SCORE, never exceed it nor wrap.
REQ-016 At beat-end, hold_left>1 SHALL decrement; hold_left==1 SHALL advance: curr<=next, frame+1, fetch frame+2 (next=0 if frame+2 >= song_len).
REQ-017 The ROM fetch for an advance SHALL complete within 2 cycles; next_note stable before the following beat-end.
REQ-018 Beat-end of last frame with hold_left==1 SHALL enter DONE; curr_note, next_note, hold_left clear to 0; score, combo held.
REQ-019 PLAY + pause -> PAUSE; PAUSE + pause -> PLAY; beat counter, hit flags, hold_left frozen in PAUSE; beat output held low.
REQ-020 start in PLAY, LOAD or PAUSE SHALL be ignored; pause outside PLAY/PAUSE ignored; start and pause together in IDLE/DONE: start wins.
REQ-021 song_len changes SHALL be sampled only on the start transition.

Reset
REQ-022 reset SHALL force IDLE and zero rom_addr, curr_note, next_note, hold_left, beat, score, combo, done, all counters and flags, asynchronously, at any point incl. mid-PLAY.
REQ-023 First start after reset release SHALL behave as REQ-008.

Structure
REQ-024 State encoding, point values (10/20/30), combo thresholds (4/8) SHALL live in shared package tiles_pkg.
REQ-025 Pausable beat counter SHALL be sub-module beat_timer (ports: clk, reset, run, clear, beat, beat_end).
REQ-026 All outputs SHALL be registered.

Verification (BEAT_CYCLES=8, N_KEYS=12, song ROM model 1-cycle latency)
REQ-027 song_len=3, notes 0x001/0x002/0x004 hold 1, keys match each beat -> score 30, combo 3, DONE after 3 beats + LOAD.
REQ-028 Single note 0x010 hold 12, keys held correct throughout -> score 10*4+20*4+30*4=240, combo 12, hold_left counts 12..1.
REQ-029 Rest frame, keys pulse 0x001 for 1 cycle mid-beat -> miss, combo 0, score unchanged.
REQ-030 pause at cycle 3 of a beat, hold 20 cycles, pause again -> beat_end occurs 5 cycles after resume, beat low while paused.
REQ-031 Preload score near ceiling (long song, all hits) -> score sticks at 9990; reset mid-PLAY -> all outputs 0, state IDLE next cycle.
REQ-032 start with song_len=0 -> DONE within 1 cycle, score 0; start while PLAY -> no effect.
